i2s_rx: RTL and testbench

//  I2S slave receiver: the capture end of the serial format our DAC interface drives. Samples

---
 rtl/i2s_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_i2s_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises LRCK/BCK/DATA, deserialises Philips-I2S frames and
// strobes out one stereo PCM pair per frame. Optional peak meters under I2S_RX_PEAK_EN.
module i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int SLOT_BITS   = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i2s_lrck,
    input  logic              i2s_bck,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              locked,
    input  logic              peak_clr,
    output logic [DATA_W-1:0] peak_left,
    output logic [DATA_W-1:0] peak_right
);

    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [5:0]      SLOT_CNT = 6'(SLOT_BITS);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    logic [SYNC_STAGES-1:0] lrck_sync_reg;
    logic [SYNC_STAGES-1:0] bck_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;

    logic bck_s, lr_s, data_s;
    logic bck_prev_reg;
    logic rise_reg, lr_smp_reg, data_smp_reg;
    logic lr_prev_reg;

    state_t            state_reg;
    logic [5:0]        bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] left_hold_reg;
    logic              slot_ok_reg;
    logic [WD_W-1:0]   wd_cnt_reg;

    logic [DATA_W-1:0] left_data_reg, right_data_reg;
    logic              sample_valid_reg, frame_err_reg, locked_reg;

    logic [5:0]        cnt_inc;
    logic [DATA_W-1:0] word_next;
    logic              lr_edge;

    // Synchroniser chains: stage 0 takes the pin, each later stage the one before it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lrck_sync_reg[0] <= 1'b0;
            bck_sync_reg[0]  <= 1'b0;
            data_sync_reg[0] <= 1'b0;
        end else begin
            lrck_sync_reg[0] <= i2s_lrck;
            bck_sync_reg[0]  <= i2s_bck;
            data_sync_reg[0] <= i2s_data;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lrck_sync_reg[gi] <= 1'b0;
                    bck_sync_reg[gi]  <= 1'b0;
                    data_sync_reg[gi] <= 1'b0;
                end else begin
                    lrck_sync_reg[gi] <= lrck_sync_reg[gi-1];
                    bck_sync_reg[gi]  <= bck_sync_reg[gi-1];
                    data_sync_reg[gi] <= data_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign bck_s  = bck_sync_reg[SYNC_STAGES-1];
    assign lr_s   = lrck_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];

    // Registered rise pulse with DATA/LRCK captured in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bck_prev_reg <= 1'b0;
            rise_reg     <= 1'b0;
            lr_smp_reg   <= 1'b0;
            data_smp_reg <= 1'b0;
        end else begin
            bck_prev_reg <= bck_s;
            rise_reg     <= bck_s & ~bck_prev_reg;
            lr_smp_reg   <= lr_s;
            data_smp_reg <= data_s;
        end
    end

    assign lr_edge = lr_smp_reg != lr_prev_reg;
    assign cnt_inc = (bit_cnt_reg == 6'd63) ? 6'd63 : bit_cnt_reg + 6'd1;

    // Current bit lands at DATA_W-1-bit_cnt; bits past DATA_W never match and are dropped.
    always_comb begin
        word_next = shift_reg;
        for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_reg == 6'(DATA_W - 1 - i)) begin
                word_next[i] = data_smp_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            lr_prev_reg      <= 1'b0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            left_hold_reg    <= '0;
            slot_ok_reg      <= 1'b0;
            wd_cnt_reg       <= '0;
            left_data_reg    <= '0;
            right_data_reg   <= '0;
            sample_valid_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            locked_reg       <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            if (rise_reg) begin
                wd_cnt_reg  <= '0;
                lr_prev_reg <= lr_smp_reg;
                if (lr_edge) begin
                    // The edge bit is the outgoing slot's LSB: commit with it included.
                    shift_reg   <= '0;
                    bit_cnt_reg <= '0;
                    case (state_reg)
                        IDLE: begin
                            if (!lr_smp_reg) begin
                                state_reg  <= LEFT;
                                locked_reg <= 1'b1;
                            end
                        end
                        LEFT: begin
                            left_hold_reg <= word_next;
                            slot_ok_reg   <= (cnt_inc == SLOT_CNT);
                            state_reg     <= RIGHT;
                        end
                        RIGHT: begin
                            if (slot_ok_reg && (cnt_inc == SLOT_CNT)) begin
                                left_data_reg    <= left_hold_reg;
                                right_data_reg   <= word_next;
                                sample_valid_reg <= 1'b1;
                            end else begin
                                frame_err_reg <= 1'b1;
                            end
                            state_reg <= LEFT;
                        end
                        default: begin
                            state_reg  <= IDLE;
                            locked_reg <= 1'b0;
                        end
                    endcase
                end else begin
                    shift_reg   <= word_next;
                    bit_cnt_reg <= cnt_inc;
                end
            end else begin
                if (wd_cnt_reg != WD_MAX) begin
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
                end
                // Bit clock gone: silently drop the partial frame and wait for the next LRCK fall.
                if (wd_cnt_reg == WD_MAX - 1'b1) begin
                    state_reg   <= IDLE;
                    locked_reg  <= 1'b0;
                    shift_reg   <= '0;
                    bit_cnt_reg <= '0;
                end
            end
        end
    end

    assign left_data    = left_data_reg;
    assign right_data   = right_data_reg;
    assign sample_valid = sample_valid_reg;
    assign frame_err    = frame_err_reg;
    assign locked       = locked_reg;

`ifdef I2S_RX_PEAK_EN
    logic [DATA_W-1:0] peak_left_reg, peak_right_reg;
    logic [DATA_W-1:0] left_abs, right_abs, left_base, right_base;

    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
        if (!x[DATA_W-1]) begin
            return x;
        end else if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            return -x;
        end
    endfunction

    assign left_abs   = abs_sat(left_data_reg);
    assign right_abs  = abs_sat(right_data_reg);
    assign left_base  = peak_clr ? '0 : peak_left_reg;
    assign right_base = peak_clr ? '0 : peak_right_reg;

    // A clear coinciding with a new sample clears first, then takes the new magnitude.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_left_reg  <= '0;
            peak_right_reg <= '0;
        end else if (sample_valid_reg) begin
            peak_left_reg  <= (left_abs > left_base) ? left_abs : left_base;
            peak_right_reg <= (right_abs > right_base) ? right_abs : right_base;
        end else if (peak_clr) begin
            peak_left_reg  <= '0;
            peak_right_reg <= '0;
        end
    end

    assign peak_left  = peak_left_reg;
    assign peak_right = peak_right_reg;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_left       = '0;
    assign peak_right      = '0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: a BFM drives I2S frames at BCK = clk/8 and queues the expected
// strobe; a monitor pops and compares on every sample_valid / frame_err.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i2s_lrck = 1'b0;
    logic        i2s_bck = 1'b0;
    logic        i2s_data = 1'b0;
    logic        peak_clr = 1'b0;
    logic [15:0] left_data, right_data, peak_left, peak_right;
    logic        sample_valid, frame_err, locked;

    always #5 clk = ~clk;

    i2s_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2s_lrck    (i2s_lrck),
        .i2s_bck     (i2s_bck),
        .i2s_data    (i2s_data),
        .left_data   (left_data),
        .right_data  (right_data),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .locked      (locked),
        .peak_clr    (peak_clr),
        .peak_left   (peak_left),
        .peak_right  (peak_right)
    );

    typedef struct {
        logic        err;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          passed = 0;
    logic        pend = 1'b0;
    logic [15:0] last_l = 16'h0;
    logic [15:0] last_r = 16'h0;
    logic        clr_arm = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: one line per DUT strobe.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rst_n && (sample_valid || frame_err)) begin
                check("valid_err_exclusive", {31'b0, sample_valid & frame_err}, 32'h0);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {31'b0, frame_err}, 32'h2);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind_err", {31'b0, frame_err}, {31'b0, e.err});
                    check("left_data", {16'b0, left_data}, {16'b0, e.l});
                    check("right_data", {16'b0, right_data}, {16'b0, e.r});
                    $display("t=%0t %s L=%04h R=%04h", $time, frame_err ? "frame_err" : "sample",
                             left_data, right_data);
                end
            end
        end
    end

    // Pulses peak_clr during the sample_valid cycle when armed.
    initial begin
        forever begin
            @(negedge clk);
            if (clr_arm && sample_valid) begin
                peak_clr = 1'b1;
                @(posedge clk);
                #1 peak_clr = 1'b0;
            end
        end
    end

    task automatic bit_period(input logic lr, input logic d);
        i2s_bck  = 1'b0;
        i2s_lrck = lr;
        i2s_data = d;
        repeat (4) @(posedge clk);
        #1 i2s_bck = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // First BCK of a slot still carries the previous slot's LSB (1-bit delay).
    task automatic send_slot(input logic lr, input logic [15:0] s, input int n);
        logic [23:0] pat;
        pat = {s, 8'hA5};
        for (int i = 0; i < n; i++) begin
            if (i == 0) bit_period(lr, pend);
            else bit_period(lr, pat[24-i]);
        end
        pend = pat[24-n];
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr,
                              input bit push);
        exp_t e;
        if (push) begin
            if (nl == 24 && nr == 24) begin
                e.err = 1'b0; e.l = l; e.r = r;
                last_l = l; last_r = r;
            end else begin
                e.err = 1'b1; e.l = last_l; e.r = last_r;
            end
            sb.push_back(e);
        end
        send_slot(1'b0, l, nl);
        send_slot(1'b1, r, nr);
    endtask

    task automatic start_stream();
        send_slot(1'b1, 16'h0000, 5);
    endtask

    task automatic flush();
        bit_period(1'b0, pend);
    endtask

    task automatic gap(input bit check_early);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        if (check_early) check("locked_before_timeout", {31'b0, locked}, 32'h1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("locked_after_timeout", {31'b0, locked}, 32'h0);
        check("scoreboard_drained", sb.size(), 32'h0);
    endtask

    initial begin
        logic [15:0] exp_pl, exp_pr;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_left", {16'b0, left_data}, 32'h0);
        check("rst_right", {16'b0, right_data}, 32'h0);
        check("rst_valid", {31'b0, sample_valid}, 32'h0);
        check("rst_err", {31'b0, frame_err}, 32'h0);
        check("rst_locked", {31'b0, locked}, 32'h0);
        check("rst_peak_left", {16'b0, peak_left}, 32'h0);
        check("rst_peak_right", {16'b0, peak_right}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame
        start_stream();
        send_frame(16'h1234, 16'hFEDC, 24, 24, 1'b1);
        flush();
        gap(1'b0);

        // Mid-right-slot start: partial slot dropped, lock on first LRCK fall
        @(negedge clk);
        check("unlocked_before_stream", {31'b0, locked}, 32'h0);
        start_stream();
        @(negedge clk);
        check("unlocked_partial_slot", {31'b0, locked}, 32'h0);
        send_frame(16'h7FFF, 16'h8000, 24, 24, 1'b1);
        @(negedge clk);
        check("locked_after_lrck_fall", {31'b0, locked}, 32'h1);
        flush();
        gap(1'b0);

        // Bad slot lengths (23 and 1) between good frames
        start_stream();
        send_frame(16'h1111, 16'h2222, 23, 24, 1'b1);
        send_frame(16'h3333, 16'h4444, 24, 24, 1'b1);
        send_frame(16'h5555, 16'h6666, 1, 24, 1'b1);
        send_frame(16'h0001, 16'hFFFF, 24, 24, 1'b1);
        flush();
        gap(1'b0);

        // Watchdog timing, then relock with correct data
        start_stream();
        send_frame(16'h0A0A, 16'h5050, 24, 24, 1'b1);
        flush();
        gap(1'b1);
        start_stream();
        send_frame(16'hA5A5, 16'h0F0F, 24, 24, 1'b1);
        flush();
        gap(1'b0);

        // Reset mid left slot
        start_stream();
        send_frame(16'hCAFE, 16'hBEEF, 24, 24, 1'b1);
        fork
            send_frame(16'h9999, 16'h8888, 24, 24, 1'b0);
            begin
                repeat (80) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                last_l = 16'h0;
                last_r = 16'h0;
                @(negedge clk);
                check("midrst_left", {16'b0, left_data}, 32'h0);
                check("midrst_right", {16'b0, right_data}, 32'h0);
                check("midrst_locked", {31'b0, locked}, 32'h0);
                check("midrst_valid", {31'b0, sample_valid}, 32'h0);
            end
        join
        send_frame(16'h0102, 16'h0304, 24, 24, 1'b1);
        flush();
        gap(1'b0);

        // Peak meters
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_l = 16'h0;
        last_r = 16'h0;
        start_stream();
        send_frame(16'h8000, 16'h0100, 24, 24, 1'b1);
        send_frame(16'h0010, 16'hFF00, 24, 24, 1'b1);
        flush();
        gap(1'b0);
`ifdef I2S_RX_PEAK_EN
        exp_pl = 16'h7FFF; exp_pr = 16'h0100;
`else
        exp_pl = 16'h0000; exp_pr = 16'h0000;
`endif
        check("peak_left_max", {16'b0, peak_left}, {16'b0, exp_pl});
        check("peak_right_max", {16'b0, peak_right}, {16'b0, exp_pr});
        clr_arm = 1'b1;
        start_stream();
        send_frame(16'h0002, 16'hFFFE, 24, 24, 1'b1);
        flush();
        gap(1'b0);
        clr_arm = 1'b0;
`ifdef I2S_RX_PEAK_EN
        exp_pl = 16'h0002; exp_pr = 16'h0002;
`else
        exp_pl = 16'h0000; exp_pr = 16'h0000;
`endif
        check("peak_left_clr", {16'b0, peak_left}, {16'b0, exp_pl});
        check("peak_right_clr", {16'b0, peak_right}, {16'b0, exp_pr});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
